instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller's fetch port. Hits return a 32-bit instruction one cycle after the request. Misses issue a word fetch to the memory controller, hold the request until the controller's valid pulse, then fill the line and forward the word. Also supports a full invalidate (flush) for instruction-stream changes.

## Interface
- INDEX_W, 6: log2 of line count; one 32-bit word per line, 2^INDEX_W lines.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; low freezes all state and outputs.
- flush  in  1  invalidate all lines; abandon any outstanding miss response.
- if_req  in  1  fetch request from IF stage.
- if_pc  in  32  request address; word-aligned.
- if_valid  out  1  one-cycle pulse: if_instr holds the instruction for the accepted request.
- if_instr  out  32  instruction word.
- mem_fet_ena  out  1  fetch request to memory controller; held high until mem_valid.
- mem_addr  out  32  word address for the fetch; stable while mem_fet_ena is high.
- mem_valid  in  1  one-cycle pulse from the memory controller; mem_data is valid.
- mem_data  in  32  fetched word, little-endian assembled.

## Operation
- Address split:
  - index = if_pc[INDEX_W+1:2]
  - tag = if_pc[31:INDEX_W+2]
- Storage per line: valid bit, tag, 32-bit data.
- States:
  - IDLE: accepting requests.
  - MISS: fetch outstanding, response wanted.
  - DROP: fetch outstanding, response to be discarded.
- IDLE, if_req=1, hit (valid and tag equal): if_valid<=1, if_instr<=line data, stay in IDLE.
- IDLE, if_req=1, miss:
  - mem_fet_ena<=1, mem_addr<=if_pc.
  - Latch index and tag, go to MISS.
  - if_valid<=0.
- IDLE, if_req=0: if_valid<=0.
- MISS:
  - if_req/if_pc are ignored.
  - IF holds them stable until if_valid.
- MISS, mem_valid=1:
  - Write line: valid=1, latched tag, mem_data.
  - if_valid<=1, if_instr<=mem_data.
  - mem_fet_ena<=0, go to IDLE.
- DROP, mem_valid=1: mem_fet_ena<=0, no line write, if_valid stays 0, go to IDLE.
- flush=1, any state:
  - Clears every valid bit at that edge.
  - if_valid<=0; no hit is served that cycle.
  - MISS goes to DROP; mem_fet_ena stays high, because the controller cannot cancel an accepted fetch.
  - IDLE stays IDLE, and a same-cycle if_req is not accepted.
- flush and mem_valid in the same cycle while in MISS: the word is discarded, valid bits are cleared, the state goes to IDLE, and if_valid stays 0.
- Conflict: a miss fill overwrites the indexed line unconditionally; there is no write-back (read-only cache).
- rdy=0: no state, storage, or output register changes. The memory controller freezes on the same rdy, so no mem_valid is lost.
- rst: applies regardless of rdy.
  - All valid bits 0, state IDLE.
  - if_valid=0, if_instr=0, mem_fet_ena=0, mem_addr=0.
  - Reset mid-miss drops the request; the controller is reset by the same rst.

## Timing
- All outputs are registered.
- Hit latency: if_req sampled at edge N gives if_valid high during cycle N+1. Back-to-back hits give one instruction per cycle.
- Miss:
  - mem_fet_ena rises at edge N.
  - The controller samples it at edge N+1.
  - The fetch ends in the mem_valid pulse. mem_fet_ena falls at the same edge that samples mem_valid, so the controller sees it low when it leaves its post-fetch stall.
  - if_valid is asserted at that same edge: miss latency = controller fetch latency + 1 cycle.
- The controller may delay the fetch in favour of load/store traffic; the cache waits indefinitely in MISS/DROP with no timeout.
- After a fill, the same address hits on the next request: a request at the edge following if_valid gets if_valid one cycle later.
- mem_addr changes only on the IDLE→MISS transition.

## Test plan
- Cold miss: reset, if_req with if_pc=0x0000_0100 -> mem_fet_ena=1, mem_addr=0x100. Mem model pulses mem_valid with mem_data=0x0051_0093 after 6 cycles -> same edge: if_valid=1, if_instr=0x00510093, mem_fet_ena=0.
- Hit: re-request 0x100 -> if_valid next cycle with 0x00510093, mem_fet_ena stays 0. Four consecutive hit addresses -> four consecutive if_valid cycles.
- Conflict eviction (INDEX_W=6): fill 0x100, then request 0x200 (same index, different tag) -> miss and fill. Then 0x100 -> miss again, mem_addr=0x100.
- Flush mid-miss: miss on 0x300, assert flush 2 cycles later, then mem_valid -> no if_valid, mem_fet_ena drops. Next request to 0x100 (previously filled) -> miss.
- rdy stall: during a hit and during a miss, hold rdy=0 for 3 cycles -> outputs and state frozen. Response resumes with unchanged values after rdy=1.
- Reset mid-miss: rst while in MISS -> next cycle mem_fet_ena=0, if_valid=0, all lines invalid. Request for the prior address misses.

Source files
------------

// File: rtl/instr_cache_if.sv
// instr_cache_if: bundle of the fetch-side and memory-side signals of the
// instruction cache.
//
// Handshake rules:
//   if_req/if_pc : IF asserts if_req with a word-aligned if_pc. Once the cache
//                  has taken a miss, IF holds both stable until if_valid.
//   if_valid     : one-cycle pulse; if_instr holds the instruction for the
//                  accepted request in that cycle.
//   mem_fet_ena  : held high from the miss until the edge that samples the
//                  controller's one-cycle mem_valid pulse. mem_addr is stable
//                  the whole time mem_fet_ena is high.
//   flush        : level, sampled every cycle; invalidates all lines.
//
// Modports: slave = the cache, master = the IF stage plus memory controller
// side (the testbench).
interface instr_cache_if;
  logic        flush;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        mem_fet_ena;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport slave (
    input  flush, if_req, if_pc, mem_valid, mem_data,
    output if_valid, if_instr, mem_fet_ena, mem_addr
  );

  modport master (
    output flush, if_req, if_pc, mem_valid, mem_data,
    input  if_valid, if_instr, mem_fet_ena, mem_addr
  );
endinterface

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache with one 32-bit
// word per line. Hits answer one cycle after the request; misses fetch the
// word from the memory controller, fill the line and forward the word.
// A flush invalidates all lines and discards any outstanding response.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset (wins over rdy)
//   rdy          global ready; low freezes all state and outputs
//   bus          instr_cache_if.slave (IF request/response, memory fetch)
//   dbg_state_o  current FSM state (IDLE=0, MISS=1, DROP=2)
module instr_cache #(
  parameter int INDEX_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  instr_cache_if.slave  bus,
  output logic [1:0]    dbg_state_o
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // accepting requests
    MISS = 2'd1,  // fetch outstanding, response wanted
    DROP = 2'd2   // fetch outstanding, response discarded
  } state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              fet_q, fet_d;
  logic [31:0]       addr_q, addr_d;
  logic              fill_en;

  logic [INDEX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit;

  assign req_idx = bus.if_pc[INDEX_W+1:2];
  assign req_tag = bus.if_pc[31:INDEX_W+2];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // mem_addr only changes on IDLE->MISS, so it doubles as the latched
  // index/tag of the outstanding miss.
  assign fill_idx = addr_q[INDEX_W+1:2];
  assign fill_tag = addr_q[31:INDEX_W+2];

  // Word-offset bits carry no information for word-aligned fetches.
  logic unused_bits;
  assign unused_bits = ^{bus.if_pc[1:0], addr_q[1:0]};

  always_comb begin
    state_d    = state_q;
    if_valid_d = 1'b0;
    if_instr_d = if_instr_q;
    fet_d      = fet_q;
    addr_d     = addr_q;
    fill_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush cycle serves nothing, not even a hit.
        if (bus.if_req && !bus.flush) begin
          if (hit) begin
            if_valid_d = 1'b1;
            if_instr_d = data_q[req_idx];
          end else begin
            fet_d   = 1'b1;
            addr_d  = bus.if_pc;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        if (bus.mem_valid) begin
          fet_d   = 1'b0;
          state_d = IDLE;
          if (!bus.flush) begin
            fill_en    = 1'b1;
            if_valid_d = 1'b1;
            if_instr_d = bus.mem_data;
          end
        end else if (bus.flush) begin
          // The controller cannot cancel an accepted fetch: keep
          // mem_fet_ena high and throw the word away when it arrives.
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_valid) begin
          fet_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      fet_q      <= 1'b0;
      addr_q     <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      fet_q      <= fet_d;
      addr_q     <= addr_d;
      if (bus.flush) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data need no reset: they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_data;
    end
  end

  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.mem_fet_ena = fet_q;
  assign bus.mem_addr    = addr_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed test of instr_cache against a transaction-level
// model (cache contents kept as "which address lives in which line"), plus
// hand-computed literal expectations for the main scenarios.
module tb_instr_cache;
  localparam int INDEX_W = 6;
  localparam int LINES   = 1 << INDEX_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  instr_cache_if ifc();

  instr_cache #(.INDEX_W(INDEX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (ifc),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0051_0093;
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  // ---------------- memory controller model ----------------
  int          mem_lat = 6;
  bit          mc_busy = 0;
  int          mc_cnt  = 0;
  logic [31:0] mc_addr = '0;
  logic        s_fet, s_rdy, s_rst;
  logic [31:0] s_addr;

  always @(posedge clk) begin
    s_fet  = ifc.mem_fet_ena;
    s_rdy  = rdy;
    s_rst  = rst;
    s_addr = ifc.mem_addr;
    #1;
    if (s_rst) begin
      mc_busy       = 0;
      mc_cnt        = 0;
      ifc.mem_valid = 1'b0;
      ifc.mem_data  = '0;
    end else if (s_rdy) begin
      if (ifc.mem_valid) begin
        ifc.mem_valid = 1'b0;
        mc_busy       = 0;
      end else if (mc_busy) begin
        check("mem_addr_stable", s_addr, mc_addr);
        mc_cnt--;
        if (mc_cnt <= 0) begin
          ifc.mem_valid = 1'b1;
          ifc.mem_data  = mem_word(mc_addr);
        end
      end else if (s_fet) begin
        mc_busy = 1;
        mc_cnt  = mem_lat;
        mc_addr = s_addr;
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_addr [int];
  logic [31:0] m_data [int];
  bit          m_pend = 0, m_drop = 0, m_live = 0;
  int          mk;
  logic        e_valid = 0, e_fet = 0;
  logic [31:0] e_instr = '0, e_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_addr.delete();
      m_data.delete();
      m_pend  = 0;
      m_drop  = 0;
      e_valid = 0;
      e_instr = '0;
      e_fet   = 0;
      e_addr  = '0;
      m_live  = 1;
    end else if (rdy && m_live) begin
      e_valid = 0;
      if (!m_pend) begin
        if (ifc.if_req && !ifc.flush) begin
          mk = line_of(ifc.if_pc);
          if (m_addr.exists(mk) && m_addr[mk] == ifc.if_pc) begin
            e_valid = 1;
            e_instr = m_data[mk];
          end else begin
            m_pend = 1;
            m_drop = 0;
            e_fet  = 1;
            e_addr = ifc.if_pc;
          end
        end
      end else if (ifc.mem_valid) begin
        m_pend = 0;
        e_fet  = 0;
        if (!m_drop && !ifc.flush) begin
          mk         = line_of(e_addr);
          m_addr[mk] = e_addr;
          m_data[mk] = ifc.mem_data;
          e_valid    = 1;
          e_instr    = ifc.mem_data;
        end
        m_drop = 0;
      end else if (ifc.flush) begin
        m_drop = 1;
      end
      if (ifc.flush) begin
        m_addr.delete();
        m_data.delete();
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("if_valid", {31'd0, ifc.if_valid}, {31'd0, e_valid});
      check("mem_fet_ena", {31'd0, ifc.mem_fet_ena}, {31'd0, e_fet});
      check("mem_addr", ifc.mem_addr, e_addr);
      if (e_valid) check("if_instr", ifc.if_instr, e_instr);
    end
  end

  // ---------------- driver tasks ----------------
  // Issue a request, hold it until if_valid; report cycles taken and what
  // the memory-side outputs looked like one cycle after the request.
  task automatic fetch(input logic [31:0] a, output int lat, output logic fet1,
                       output logic [31:0] addr1, output logic [31:0] instr);
    @(negedge clk);
    ifc.if_req = 1'b1;
    ifc.if_pc  = a;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        fet1  = ifc.mem_fet_ena;
        addr1 = ifc.mem_addr;
      end
    end while (!ifc.if_valid && lat < 200);
    if (!ifc.if_valid) check("fetch_timeout", 32'd0, 32'd1);
    instr = ifc.if_instr;
    ifc.if_req = 1'b0;
  endtask

  int          lat, cnt;
  logic        fet1;
  logic [31:0] addr1, instr;
  logic [31:0] burst_a [4];

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    ifc.flush  = 1'b0;
    ifc.if_req = 1'b0;
    ifc.if_pc  = '0;
    repeat (2) @(negedge clk);
    check("rst_if_valid", {31'd0, ifc.if_valid}, 32'd0);
    check("rst_if_instr", ifc.if_instr, 32'd0);
    check("rst_fet", {31'd0, ifc.mem_fet_ena}, 32'd0);
    check("rst_mem_addr", ifc.mem_addr, 32'd0);
    rst = 1'b0;

    // Cold miss on 0x100.
    mem_lat = 6;
    fetch(32'h100, lat, fet1, addr1, instr);
    check("cold_fet", {31'd0, fet1}, 32'd1);
    check("cold_addr", addr1, 32'h100);
    check("cold_instr", instr, 32'h0051_0093);
    check("cold_fet_drop", {31'd0, ifc.mem_fet_ena}, 32'd0);

    // Hit on 0x100.
    fetch(32'h100, lat, fet1, addr1, instr);
    check("hit_latency", lat, 32'd1);
    check("hit_no_fet", {31'd0, fet1}, 32'd0);
    check("hit_instr", instr, 32'h0051_0093);

    // Fill three neighbours, then four back-to-back hits.
    mem_lat = 1;
    fetch(32'h104, lat, fet1, addr1, instr);
    mem_lat = 3;
    fetch(32'h108, lat, fet1, addr1, instr);
    fetch(32'h10c, lat, fet1, addr1, instr);
    check("fill_10c_instr", instr, mem_word(32'h10c));
    burst_a[0] = 32'h100; burst_a[1] = 32'h104;
    burst_a[2] = 32'h108; burst_a[3] = 32'h10c;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("burst_valid", {31'd0, ifc.if_valid}, 32'd1);
        check("burst_instr", ifc.if_instr, mem_word(burst_a[i-1]));
      end
      ifc.if_req = 1'b1;
      ifc.if_pc  = burst_a[i];
    end
    @(negedge clk);
    check("burst_valid", {31'd0, ifc.if_valid}, 32'd1);
    check("burst_instr", ifc.if_instr, mem_word(burst_a[3]));
    ifc.if_req = 1'b0;

    // Conflict eviction: 0x200 shares line 0 with 0x100.
    mem_lat = 6;
    fetch(32'h200, lat, fet1, addr1, instr);
    check("conf_200_miss", {31'd0, fet1}, 32'd1);
    check("conf_200_instr", instr, mem_word(32'h200));
    fetch(32'h100, lat, fet1, addr1, instr);
    check("conf_100_miss", {31'd0, fet1}, 32'd1);
    check("conf_100_addr", addr1, 32'h100);

    // Flush mid-miss on 0x300.
    @(negedge clk);
    ifc.if_req = 1'b1;
    ifc.if_pc  = 32'h300;
    repeat (2) @(negedge clk);
    ifc.flush  = 1'b1;
    ifc.if_req = 1'b0;
    @(negedge clk);
    ifc.flush = 1'b0;
    check("drop_fet_held", {31'd0, ifc.mem_fet_ena}, 32'd1);
    cnt = 0;
    lat = 0;
    while (ifc.mem_fet_ena && lat < 200) begin
      @(negedge clk);
      lat++;
      if (ifc.if_valid) cnt++;
    end
    check("drop_fet_fell", {31'd0, ifc.mem_fet_ena}, 32'd0);
    check("drop_no_valid", cnt, 32'd0);

    // Flush in IDLE with a same-cycle request: not accepted.
    @(negedge clk);
    ifc.flush  = 1'b1;
    ifc.if_req = 1'b1;
    ifc.if_pc  = 32'h100;
    @(negedge clk);
    check("flush_idle_valid", {31'd0, ifc.if_valid}, 32'd0);
    check("flush_idle_fet", {31'd0, ifc.mem_fet_ena}, 32'd0);
    ifc.flush  = 1'b0;
    ifc.if_req = 1'b0;
    fetch(32'h100, lat, fet1, addr1, instr);
    check("post_flush_miss", {31'd0, fet1}, 32'd1);
    check("post_flush_instr", instr, 32'h0051_0093);

    // rdy stall during a hit.
    @(negedge clk);
    ifc.if_req = 1'b1;
    ifc.if_pc  = 32'h100;
    @(negedge clk);
    check("stall_hit_valid", {31'd0, ifc.if_valid}, 32'd1);
    rdy        = 1'b0;
    ifc.if_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_hit_hold", {31'd0, ifc.if_valid}, 32'd1);
      check("stall_hit_instr", ifc.if_instr, 32'h0051_0093);
    end
    rdy = 1'b1;
    @(negedge clk);
    check("stall_hit_release", {31'd0, ifc.if_valid}, 32'd0);

    // rdy stall during a miss on 0x400.
    @(negedge clk);
    ifc.if_req = 1'b1;
    ifc.if_pc  = 32'h400;
    @(negedge clk);
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_miss_fet", {31'd0, ifc.mem_fet_ena}, 32'd1);
      check("stall_miss_addr", ifc.mem_addr, 32'h400);
    end
    rdy = 1'b1;
    lat = 0;
    while (!ifc.if_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("stall_miss_instr", ifc.if_instr, mem_word(32'h400));
    ifc.if_req = 1'b0;

    // Reset mid-miss on 0x500, with 0x104 filled beforehand.
    fetch(32'h104, lat, fet1, addr1, instr);
    fetch(32'h104, lat, fet1, addr1, instr);
    check("pre_rst_hit", lat, 32'd1);
    @(negedge clk);
    ifc.if_req = 1'b1;
    ifc.if_pc  = 32'h500;
    @(negedge clk);
    check("pre_rst_fet", {31'd0, ifc.mem_fet_ena}, 32'd1);
    @(negedge clk);
    rst        = 1'b1;
    ifc.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_miss_fet", {31'd0, ifc.mem_fet_ena}, 32'd0);
    check("rst_miss_valid", {31'd0, ifc.if_valid}, 32'd0);
    fetch(32'h500, lat, fet1, addr1, instr);
    check("post_rst_500_miss", {31'd0, fet1}, 32'd1);
    fetch(32'h104, lat, fet1, addr1, instr);
    check("post_rst_104_miss", {31'd0, fet1}, 32'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
